// File: rtl/multi_pattern_matcher_pkg.sv
// ============================================================================
// multi_pattern_matcher_pkg : shared constants and helpers for the matcher
// rev 1.0
// ============================================================================
`default_nettype none

package multi_pattern_matcher_pkg;

  localparam logic [7:0] c_wildcard_default = 8'h3F;
  localparam int         c_max_slots        = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Lowest set bit wins; an all-zero mask maps to index 0.
  function automatic int lowest_set_index(input logic [c_max_slots-1:0] mask);
    int r;
    r = 0;
    for (int i = c_max_slots - 1; i >= 0; i--) begin
      if (mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_pattern_matcher_pattern_slot.sv
// ============================================================================
// pattern_slot : one programmable pattern with length, arm flag and comparator
// rev 1.0
// ============================================================================
`default_nettype none

module pattern_slot
  import multi_pattern_matcher_pkg::*;
#(
  parameter int                N_BITS      = 8,
  parameter int                PATTERN_LEN = 8,
  parameter logic [N_BITS-1:0] WILDCARD    = N_BITS'(c_wildcard_default),
  localparam int               POS_W       = clog2(PATTERN_LEN),
  localparam int               LEN_W       = POS_W + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [POS_W-1:0]                   wr_pos,
  input  logic [N_BITS-1:0]                  wr_char,
  input  logic                               wr_last,
  input  logic                               eval_en,
  input  logic [PATTERN_LEN-1:0][N_BITS-1:0] hist,
  input  logic [LEN_W-1:0]                   fill,
  output logic                               hit,
  output logic                               armed
);

  logic [PATTERN_LEN-1:0][N_BITS-1:0] r_pat;
  logic [LEN_W-1:0]                   r_len;
  logic                               r_armed;
  logic [LEN_W-1:0]                   w_age;
  logic                               w_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_armed <= 1'b0;
    end else if (wr_en) begin
      r_pat[wr_pos] <= wr_char;
      if (wr_last) begin
        r_len   <= {1'b0, wr_pos} + LEN_W'(1);
        r_armed <= 1'b1;
      end else begin
        r_armed <= 1'b0;
      end
    end
  end

  // Pattern position i lines up with history age (len-1-i); hist[0] is newest.
  always_comb begin
    w_match = 1'b1;
    w_age   = '0;
    for (int i = 0; i < PATTERN_LEN; i++) begin
      if (LEN_W'(i) < r_len) begin
        w_age = r_len - LEN_W'(i) - LEN_W'(1);
        if ((r_pat[i] != WILDCARD) && (r_pat[i] != hist[w_age[POS_W-1:0]])) begin
          w_match = 1'b0;
        end
      end
    end
    hit = eval_en && r_armed && (fill >= r_len) && w_match;
  end

  assign armed = r_armed;

endmodule

`default_nettype wire

// File: rtl/multi_pattern_matcher.sv
// ============================================================================
// multi_pattern_matcher : streaming matcher against N runtime-programmable patterns
// rev 1.0
// ============================================================================
`default_nettype none

module multi_pattern_matcher
  import multi_pattern_matcher_pkg::*;
#(
  parameter int                N_BITS      = 8,
  parameter int                PATTERN_LEN = 8,
  parameter int                N_PATTERNS  = 4,
  parameter int                CNT_W       = 8,
  parameter logic [N_BITS-1:0] WILDCARD    = N_BITS'(c_wildcard_default),
  localparam int               POS_W       = clog2(PATTERN_LEN),
  localparam int               IDX_W       = (N_PATTERNS > 1) ? clog2(N_PATTERNS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BITS-1:0]     char_in,
  input  logic                  char_valid,
  input  logic                  overlap_en,
  input  logic                  pat_wr_valid,
  input  logic [IDX_W-1:0]      pat_wr_sel,
  input  logic [POS_W-1:0]      pat_wr_pos,
  input  logic [N_BITS-1:0]     pat_wr_char,
  input  logic                  pat_wr_last,
  output logic                  match_valid,
  output logic [N_PATTERNS-1:0] match_mask,
  output logic [IDX_W-1:0]      match_index,
  output logic [IDX_W-1:0]      last_index,
  output logic [CNT_W-1:0]      hit_count,
  output logic [N_PATTERNS-1:0] armed
);

  localparam int LEN_W = POS_W + 1;

  logic [PATTERN_LEN-1:0][N_BITS-1:0] r_hist;
  logic [PATTERN_LEN-1:0][N_BITS-1:0] w_hist_next;
  logic [LEN_W-1:0]                   r_fill;
  logic [LEN_W-1:0]                   w_fill_base;
  logic [LEN_W-1:0]                   w_fill_next;
  logic [N_PATTERNS-1:0]              w_hit;
  logic [N_PATTERNS-1:0]              r_hit_mask;
  logic                               w_flush;
  logic [IDX_W-1:0]                   w_lowest;

  // The flush takes effect on the edge that raises the hit pulse, so a
  // character arriving on that same edge opens the next window (fill = 1).
  always_comb begin
    w_hist_next = r_hist;
    if (char_valid) begin
      w_hist_next[0] = char_in;
      for (int i = 1; i < PATTERN_LEN; i++) w_hist_next[i] = r_hist[i-1];
    end
    w_flush     = (|r_hit_mask) && !overlap_en;
    w_fill_base = w_flush ? '0 : r_fill;
    w_fill_next = w_fill_base;
    if (char_valid && (w_fill_base != LEN_W'(PATTERN_LEN))) begin
      w_fill_next = w_fill_base + LEN_W'(1);
    end
  end

  generate
    for (genvar k = 0; k < N_PATTERNS; k++) begin : g_slot
      pattern_slot #(
        .N_BITS      (N_BITS),
        .PATTERN_LEN (PATTERN_LEN),
        .WILDCARD    (WILDCARD)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pat_wr_valid && (pat_wr_sel == IDX_W'(k))),
        .wr_pos  (pat_wr_pos),
        .wr_char (pat_wr_char),
        .wr_last (pat_wr_last),
        .eval_en (char_valid),
        .hist    (w_hist_next),
        .fill    (w_fill_next),
        .hit     (w_hit[k]),
        .armed   (armed[k])
      );
    end
  endgenerate

  assign w_lowest = IDX_W'(lowest_set_index(c_max_slots'(r_hit_mask)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist      <= '0;
      r_fill      <= '0;
      r_hit_mask  <= '0;
      match_valid <= 1'b0;
      match_mask  <= '0;
      match_index <= '0;
      last_index  <= '0;
      hit_count   <= '0;
    end else begin
      r_hist      <= w_hist_next;
      r_fill      <= w_fill_next;
      r_hit_mask  <= w_hit;
      match_valid <= |r_hit_mask;
      match_mask  <= r_hit_mask;
      match_index <= w_lowest;
      if (|r_hit_mask) begin
        last_index <= w_lowest;
        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_pattern_matcher.sv
// Self-checking bench: directed scenarios plus random traffic against a
// window/queue reference model of the matching rules.
`default_nettype none

module tb_multi_pattern_matcher;

  localparam int NB = 8;
  localparam int PL = 8;
  localparam int NP = 4;
  localparam int CW = 3;
  localparam int IW = 2;
  localparam int PW = 3;
  localparam logic [7:0] WC = 8'h3F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] char_in = '0;
  logic          char_valid = 1'b0;
  logic          overlap_en = 1'b0;
  logic          pat_wr_valid = 1'b0;
  logic [IW-1:0] pat_wr_sel = '0;
  logic [PW-1:0] pat_wr_pos = '0;
  logic [NB-1:0] pat_wr_char = '0;
  logic          pat_wr_last = 1'b0;
  logic          match_valid;
  logic [NP-1:0] match_mask;
  logic [IW-1:0] match_index;
  logic [IW-1:0] last_index;
  logic [CW-1:0] hit_count;
  logic [NP-1:0] armed;

  always #5 clk = ~clk;

  multi_pattern_matcher #(
    .N_BITS(NB), .PATTERN_LEN(PL), .N_PATTERNS(NP), .CNT_W(CW), .WILDCARD(WC)
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .overlap_en(overlap_en), .pat_wr_valid(pat_wr_valid), .pat_wr_sel(pat_wr_sel),
    .pat_wr_pos(pat_wr_pos), .pat_wr_char(pat_wr_char), .pat_wr_last(pat_wr_last),
    .match_valid(match_valid), .match_mask(match_mask), .match_index(match_index),
    .last_index(last_index), .hit_count(hit_count), .armed(armed)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [NP-1:0] seen_mask = '0;

  // Reference model: patterns as arrays, the current match window as a queue.
  logic [7:0]    m_pat [NP][PL];
  int            m_len [NP];
  bit            m_armed [NP];
  logic [7:0]    m_win [$];
  logic [NP-1:0] m_pend;
  bit            e_valid;
  logic [NP-1:0] e_mask;
  int            e_idx, e_last, e_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      for (int i = 0; i < PL; i++) m_pat[k][i] = 8'h00;
      m_len[k] = 0;
      m_armed[k] = 1'b0;
    end
    m_win.delete();
    m_pend = '0; e_valid = 1'b0; e_mask = '0; e_idx = 0; e_last = 0; e_cnt = 0;
  endtask

  function automatic int lowest(input logic [NP-1:0] m);
    for (int k = 0; k < NP; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic logic [NP-1:0] eval_window();
    logic [NP-1:0] r;
    bit ok;
    r = '0;
    for (int k = 0; k < NP; k++) begin
      if (m_armed[k] && m_win.size() >= m_len[k]) begin
        ok = 1'b1;
        for (int i = 0; i < m_len[k]; i++) begin
          if (m_pat[k][i] != WC && m_pat[k][i] != m_win[m_win.size() - m_len[k] + i]) ok = 1'b0;
        end
        r[k] = ok;
      end
    end
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_armed();
    logic [NP-1:0] r;
    for (int k = 0; k < NP; k++) r[k] = m_armed[k];
    return r;
  endfunction

  task automatic model_edge(input bit v, input logic [7:0] c, input bit wv, input int ws,
                            input int wp, input logic [7:0] wch, input bit wl, input bit ov);
    logic [NP-1:0] nh;
    nh = '0;
    if (m_pend != '0 && !ov) m_win.delete();
    if (v) begin
      m_win.push_back(c);
      if (m_win.size() > PL) void'(m_win.pop_front());
      nh = eval_window();
    end
    e_valid = (m_pend != '0);
    e_mask  = m_pend;
    e_idx   = lowest(m_pend);
    if (e_valid) begin
      e_last = e_idx;
      if (e_cnt < (1 << CW) - 1) e_cnt++;
    end
    m_pend = nh;
    if (wv) begin
      m_pat[ws][wp] = wch;
      if (wl) begin
        m_len[ws] = wp + 1;
        m_armed[ws] = 1'b1;
      end else begin
        m_armed[ws] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check("match_valid", 32'(match_valid), 32'(e_valid));
    check("match_mask",  32'(match_mask),  32'(e_mask));
    check("match_index", 32'(match_index), 32'(e_idx));
    check("last_index",  32'(last_index),  32'(e_last));
    check("hit_count",   32'(hit_count),   32'(e_cnt));
    check("armed",       32'(armed),       32'(exp_armed()));
  endtask

  task automatic step(input bit v, input logic [7:0] c, input bit wv, input int ws,
                      input int wp, input logic [7:0] wch, input bit wl);
    char_valid   = v;
    char_in      = c;
    pat_wr_valid = wv;
    pat_wr_sel   = IW'(ws);
    pat_wr_pos   = PW'(wp);
    pat_wr_char  = wch;
    pat_wr_last  = wl;
    @(posedge clk);
    model_edge(v, c, wv, ws, wp, wch, wl, overlap_en);
    #1;
    check_outputs();
    if (match_valid) begin
      pulses++;
      seen_mask = match_mask;
    end
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, 0, 0, 8'h00, 1'b0);
  endtask

  task automatic prog(input int slot, input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 8'h00, 1'b1, slot, i, s[i], i == s.len() - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 0, 0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    char_valid = 1'b0;
    pat_wr_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", 32'(match_valid), 32'd0);
    check("rst_mask",  32'(match_mask),  32'd0);
    check("rst_index", 32'(match_index), 32'd0);
    check("rst_last",  32'(last_index),  32'd0);
    check("rst_count", 32'(hit_count),   32'd0);
    check("rst_armed", 32'(armed),       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    seen_mask = '0;
  endtask

  bit         r_v, r_wv, r_wl;
  logic [7:0] r_c, r_wc;
  int         r_ws, r_wp;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single pattern in a stream
    overlap_en = 1'b1;
    prog(0, "GOLD");
    pulses = 0;
    feed("xxGOLDxx");
    idle(2);
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_mask",   32'(seen_mask), 32'h1);
    check("t1_count",  32'(hit_count), 32'd1);

    // Overlapping versus flushed matches
    do_reset();
    overlap_en = 1'b1;
    prog(1, "AA");
    feed("AAAA");
    idle(2);
    check("t2_overlap_pulses", 32'(pulses), 32'd3);
    do_reset();
    overlap_en = 1'b0;
    prog(1, "AA");
    feed("AAAA");
    idle(2);
    check("t2_flush_pulses", 32'(pulses), 32'd2);

    // Wildcard slot alongside an exact slot
    do_reset();
    overlap_en = 1'b0;
    prog(2, "G?LD");
    prog(0, "GOLD");
    feed("GALD");
    feed("GOLD");
    idle(2);
    check("t3_pulses", 32'(pulses), 32'd2);
    check("t3_mask",   32'(seen_mask), 32'h5);
    check("t3_last",   32'(last_index), 32'd0);

    // Write concurrent with the final character; slot disarmed afterwards
    do_reset();
    overlap_en = 1'b1;
    prog(0, "GOLD");
    feed("GOL");
    step(1'b1, "D", 1'b1, 0, 1, "O", 1'b0);
    idle(2);
    check("t4_concurrent_hit", 32'(pulses), 32'd1);
    check("t4_disarmed", 32'(armed), 32'd0);
    pulses = 0;
    feed("GOLD");
    idle(2);
    check("t4_no_hit", 32'(pulses), 32'd0);
    step(1'b0, 8'h00, 1'b1, 0, 3, "D", 1'b1);
    feed("GOLD");
    idle(2);
    check("t4_rearmed_hit", 32'(pulses), 32'd1);

    // Counter saturation
    do_reset();
    overlap_en = 1'b1;
    prog(1, "AA");
    feed("AAAAAAAAAA");
    idle(2);
    check("t5_pulses", 32'(pulses), 32'd9);
    check("t5_saturated", 32'(hit_count), 32'd7);

    // Reset in the middle of a pattern
    do_reset();
    overlap_en = 1'b1;
    prog(0, "GOLD");
    feed("GO");
    do_reset();
    feed("LD");
    idle(2);
    check("t6_no_pulse", 32'(pulses), 32'd0);
    prog(0, "GOLD");
    feed("GOLD");
    idle(2);
    check("t6_pulse", 32'(pulses), 32'd1);

    // Random traffic with live reprogramming
    do_reset();
    prog(0, "AB");
    prog(1, "A?A");
    prog(2, "BCA");
    prog(3, "??");
    for (int n = 0; n < 800; n++) begin
      r_v  = ($urandom_range(3) != 0);
      r_c  = 8'h41 + 8'($urandom_range(2));
      r_wv = ($urandom_range(7) == 0);
      r_ws = $urandom_range(NP - 1);
      r_wp = $urandom_range(3);
      r_wc = ($urandom_range(3) == 0) ? WC : 8'h41 + 8'($urandom_range(2));
      r_wl = ($urandom_range(1) == 1);
      overlap_en = ($urandom_range(1) == 1);
      step(r_v, r_c, r_wv, r_ws, r_wp, r_wc, r_wl);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_pattern_matcher.md
# multi_pattern_matcher

Streaming character matcher that compares a UART-fed byte stream against up to `N_PATTERNS` runtime-programmable patterns, each up to `PATTERN_LEN` characters, with a single-character wildcard. It replaces the single fixed-pattern search stage between the UART receiver and the seven-segment/LED display logic. Per-pattern hit flags, a priority index, a saturating hit counter and a held last-hit index are reported. An overlap mode selects whether matches may share characters.

## Interface
- `N_BITS`, 8, character width
- `PATTERN_LEN`, 8, maximum characters per pattern (≥2)
- `N_PATTERNS`, 4, number of pattern slots (≥1)
- `CNT_W`, 8, width of the hit counter
- `WILDCARD`, 8'h3F (`?`), pattern character that matches any input
- Derived localparams: `POS_W = $clog2(PATTERN_LEN)`, `IDX_W = max(1,$clog2(N_PATTERNS))`
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, asynchronous, active-high
- `char_in` in N_BITS: stream character
- `char_valid` in 1: one-cycle strobe, char_in sampled on that edge; back-to-back allowed
- `overlap_en` in 1: 1 = overlapping matches, 0 = window flushed after a hit
- `pat_wr_valid` in 1: pattern write strobe
- `pat_wr_sel` in IDX_W: target slot
- `pat_wr_pos` in POS_W: character position, 0 = first (oldest) character
- `pat_wr_char` in N_BITS: character to write
- `pat_wr_last` in 1: this write is the final character; sets length = pat_wr_pos+1 and arms the slot
- `match_valid` out 1: one-cycle hit pulse
- `match_mask` out N_PATTERNS: slots that hit on this character
- `match_index` out IDX_W: lowest set bit of match_mask
- `last_index` out IDX_W: match_index of the most recent hit, held
- `hit_count` out CNT_W: total hit events, saturating
- `armed` out N_PATTERNS: slot armed flags

## Operation
- History: shift register of `PATTERN_LEN` characters plus fill counter `fill` (0..PATTERN_LEN, saturating); each char_valid shifts char_in in as newest and increments fill.
- Slot k hits when armed[k], fill ≥ len[k], and for every i < len[k] the pattern char at position i equals history char at age (len[k]-1-i), or the pattern char equals WILDCARD.
- Evaluation uses the history including the just-sampled character and the slot contents as of before that edge.
- Hit event: any slot hits → match_valid=1, match_mask, match_index, last_index<=match_index, hit_count+1 (saturating at all-ones). Multiple slots hitting together count as one event.
- overlap_en=0 and a hit: fill is cleared, so the next window starts with the next character (fill=1 if char_valid coincides with the hit pulse). overlap_en=1: fill untouched.
- Pattern write: stores the char; any write with pat_wr_last=0 disarms the slot; pat_wr_last=1 sets len and arms it. An unarmed slot never hits. No byte-level mask: unwritten positions keep old contents.
- Write and char_valid in the same cycle: the character is evaluated against pre-write contents; write visible from the next character.
- overlap_en is sampled at the hit pulse edge.

## Timing
- Char sampled on edge E → match_valid/match_mask/match_index high for exactly the cycle after edge E+1 (one-cycle latency, registered outputs); last_index and hit_count update on edge E+1.
- Throughput: one character per clock.
- Reset (any time, including mid-pattern): history, fill, len, armed, pattern storage cleared to 0; match_valid=0, match_mask=0, match_index=0, last_index=0, hit_count=0, armed=0. A pending hit pulse is dropped.

## Structure
- Shared package: WILDCARD default, function `clog2`, function `lowest_set_index`.
- One sub-module `pattern_slot` (storage, len, armed, compare against the history vector, output hit); instantiated N_PATTERNS times via generate. Top holds history, fill, priority encode, counters.

## Test plan
- Slot 0 = "GOLD", feed "xxGOLDxx" every cycle → one match_valid the cycle after 'D', mask=0001, index=0, hit_count=1.
- Slot 1 = "AA", overlap_en=1, feed "AAAA" → 3 pulses; repeat with overlap_en=0 after reset → 2 pulses.
- Slot 2 = "G?LD", feed "GALD" and "GOLD" → 2 hits; slot 0 = "GOLD" also armed → second hit mask=0101, index=0, last_index=0.
- Rewrite slot 0 position 1 with pat_wr_last=0 concurrent with 'D' of "GOLD" → that 'D' still hits; a later "GOLD" does not hit (slot disarmed) until pat_wr_last write.
- CNT_W=2, 5 hit events → hit_count saturates at 3.
- Assert rst between 'O' and 'L' of "GOLD" → no pulse, all outputs 0, armed=0; reprogram, full "GOLD" hits once.
